// File: rtl/vbus_2_parallel.sv
// vbus_2_parallel: rebuilds a parallel fval/lval/dval video bus from a VBUS pixel stream
module vbus_2_parallel #(
    parameter int DW_VD = 12,
    parameter int DW_VX = 4,
    parameter int LINES = 480,
    parameter int FV_LV_GAP = 4,
    parameter int H_BLANK = 16,
    parameter int V_BLANK = 32,
    localparam int BPP = DW_VD + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW_VD-1:0] s_vb_dat,
    input  logic             s_vb_val,
    output logic             s_vb_rdy,
    input  logic [DW_VX-1:0] s_vb_aux,
    output logic             fval,
    output logic             lval,
    output logic             dval,
    output logic [BPP-1:0]   pix_data,
    output logic             frm_err
);
    localparam int LCW = $clog2(LINES + 1);
    localparam int BMAX_FH = (FV_LV_GAP > H_BLANK) ? FV_LV_GAP : H_BLANK;
    localparam int BMAX = (BMAX_FH > V_BLANK) ? BMAX_FH : V_BLANK;
    localparam int BCW = $clog2(BMAX + 1);
    localparam logic [BCW-1:0] FRONT_END = BCW'(FV_LV_GAP - 1);
    localparam logic [BCW-1:0] HB_END = BCW'(H_BLANK - 1);
    localparam logic [BCW-1:0] VB_END = BCW'(V_BLANK);
    localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES);

    typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, VBLANK} state_t;

    state_t state;
    logic [LCW-1:0] line_cnt;
    logic [LCW-1:0] line_cnt_nxt;
    logic [BCW-1:0] cnt;
    logic [BCW-1:0] blank_end;
    logic first;
    logic sof;
    logic eol;
    logic xfer;
    logic bdone;
    logic unused_aux;

    assign sof = s_vb_aux[0];
    assign eol = s_vb_aux[1];
    assign unused_aux = ^s_vb_aux[DW_VX-1:3];
    assign xfer = (state == LINE) && s_vb_val;
    assign line_cnt_nxt = line_cnt + 1'b1;
    // VBLANK runs one cycle longer than V_BLANK so fval stays low at least V_BLANK+1 cycles
    assign blank_end = (state == FRONT) ? FRONT_END : (state == HBLANK) ? HB_END : VB_END;
    assign bdone = cnt == blank_end;
    // IDLE swallows non-SOF beats; a SOF beat is held until the line phase
    assign s_vb_rdy = !rst && ((state == LINE) || ((state == IDLE) && s_vb_val && !sof));

    // Frame/line sequencer with registered video outputs; fval and lval fall one cycle after the state leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            line_cnt <= '0;
            cnt <= '0;
            first <= 1'b0;
            fval <= 1'b0;
            lval <= 1'b0;
            dval <= 1'b0;
            frm_err <= 1'b0;
            pix_data <= '0;
        end else begin
            dval <= xfer;
            frm_err <= 1'b0;
            if (xfer) pix_data <= {s_vb_aux[2], s_vb_dat};
            case (state)
                IDLE: begin
                    if (s_vb_val) begin
                        if (sof) begin
                            state <= FRONT;
                            fval <= 1'b1;
                            line_cnt <= '0;
                            cnt <= '0;
                            first <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                end
                FRONT: begin
                    if (bdone) begin
                        state <= LINE;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LINE: begin
                    if (s_vb_val) begin
                        lval <= 1'b1;
                        first <= 1'b0;
                        if (sof && !first) frm_err <= 1'b1;
                        if (eol) begin
                            line_cnt <= line_cnt_nxt;
                            cnt <= '0;
                            state <= (line_cnt_nxt == LAST_LINE) ? VBLANK : HBLANK;
                        end
                    end
                end
                HBLANK: begin
                    lval <= 1'b0;
                    if (!bdone) begin
                        cnt <= cnt + 1'b1;
                    end else if (s_vb_val) begin
                        cnt <= '0;
                        if (sof) begin
                            frm_err <= 1'b1;
                            state <= VBLANK;
                        end else begin
                            state <= LINE;
                        end
                    end
                end
                VBLANK: begin
                    lval <= 1'b0;
                    fval <= 1'b0;
                    if (bdone) begin
                        state <= IDLE;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vbus_2_parallel.sv
// tb_vbus_2_parallel: randomized bench comparing the video bus against a beat-sequence framing model
module tb_vbus_2_parallel;
    localparam int LINES = 3;
    localparam int GAP = 4;
    localparam int HB = 16;
    localparam int VB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [11:0] s_vb_dat = '0;
    logic s_vb_val = 1'b0;
    logic s_vb_rdy;
    logic [3:0] s_vb_aux = '0;
    logic fval, lval, dval, frm_err;
    logic [12:0] pix_data;

    vbus_2_parallel #(
        .DW_VD(12), .DW_VX(4), .LINES(LINES),
        .FV_LV_GAP(GAP), .H_BLANK(HB), .V_BLANK(VB)
    ) dut (
        .clk(clk), .rst(rst), .s_vb_dat(s_vb_dat), .s_vb_val(s_vb_val),
        .s_vb_rdy(s_vb_rdy), .s_vb_aux(s_vb_aux), .fval(fval), .lval(lval),
        .dval(dval), .pix_data(pix_data), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus and reference model
    logic [15:0] bq[$];
    logic [12:0] expq[$];
    int m_err = 0;
    int m_lines = 0;
    bit m_open = 0;
    bit m_first = 0;
    bit m_ls = 0;
    bit rand_val = 0;

    // framing rules applied to the ordered beat sequence, independent of timing
    function automatic void model(input logic [3:0] a, input logic [11:0] d);
        if (m_open && m_ls && m_lines > 0 && a[0]) begin
            m_err++;
            m_open = 0;
        end
        if (!m_open) begin
            if (!a[0]) begin
                m_err++;
                return;
            end
            m_open = 1;
            m_lines = 0;
            m_first = 1;
        end
        expq.push_back({a[2], d});
        if (a[0] && !m_first) m_err++;
        m_first = 0;
        m_ls = a[1];
        if (a[1]) begin
            m_lines++;
            if (m_lines == LINES) m_open = 0;
        end
    endfunction

    function automatic void push(input logic [3:0] a, input logic [11:0] d);
        bq.push_back({a, d});
        model(a, d);
    endfunction

    task automatic gen_frame(input int nl, input int w, input bit inj, input logic [12:0] first);
        for (int l = 0; l < nl; l++)
            for (int p = 0; p < w; p++) begin
                logic [12:0] px;
                logic sf;
                px = (l == 0 && p == 0) ? first : 13'($urandom);
                sf = (l == 0 && p == 0) || (inj && p != 0 && $urandom_range(0, 7) == 0);
                push({1'b0, px[12], p == w - 1, sf}, px[11:0]);
            end
    endtask

    // monitor state
    int cyc = 0;
    bit p_fval = 0, p_lval = 0, seen = 0, had = 0, fif = 0;
    int lo = 0, fl = 0, dcnt = 0, last_dval = 0, errs = 0;
    int hg[$], fg[$], dc[$], lf[$], ff[$], fr[$], fd[$];
    logic [12:0] fp[$];
    int i_hg, i_fg, i_dc, i_lf, i_ff, i_fr, i_fd;

    task automatic tick(output bit took);
        @(negedge clk);
        took = s_vb_val && s_vb_rdy;
        if (dval) begin
            check("pix_avail", int'(expq.size() > 0), 1);
            if (expq.size() > 0) check("pix", pix_data, expq.pop_front());
            last_dval = cyc;
            dcnt++;
            if (fif) begin
                fd.push_back(cyc);
                fp.push_back(pix_data);
                fif = 0;
            end
        end
        if (frm_err) errs++;
        if (lval && !p_lval) begin
            if (seen) hg.push_back(lo);
            lo = 0;
        end else if (!lval && fval) lo++;
        if (!lval && p_lval) begin
            lf.push_back(cyc - last_dval);
            dc.push_back(dcnt);
            dcnt = 0;
            seen = 1;
        end
        if (fval && !p_fval) begin
            if (had) fg.push_back(fl);
            fl = 0;
            fif = 1;
            fr.push_back(cyc);
        end else if (!fval) fl++;
        if (!fval && p_fval) begin
            ff.push_back(cyc - last_dval);
            had = 1;
            seen = 0;
        end
        p_fval = fval;
        p_lval = lval;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit t;
        repeat (n) tick(t);
    endtask

    task automatic run(input int budget, input bit drain);
        int n = 0;
        bit took;
        while (bq.size() > 0 && n < budget) begin
            s_vb_val = rand_val ? 1'($urandom_range(0, 1)) : 1'b1;
            {s_vb_aux, s_vb_dat} = bq[0];
            tick(took);
            if (took) void'(bq.pop_front());
            n++;
        end
        s_vb_val = 1'b0;
        if (drain) check("drain", bq.size(), 0);
    endtask

    task automatic mark();
        i_hg = hg.size(); i_fg = fg.size(); i_dc = dc.size(); i_lf = lf.size();
        i_ff = ff.size(); i_fr = fr.size(); i_fd = fd.size();
        errs = 0;
        m_err = 0;
    endtask

    task automatic endph(input string nm, input int nfr, input int w, input bit exact);
        run(4000, 1);
        idle(VB + 30);
        check({nm, "_left"}, expq.size(), 0);
        check({nm, "_errs"}, errs, m_err);
        check({nm, "_frames"}, fr.size() - i_fr, nfr);
        for (int i = i_lf; i < lf.size(); i++) check({nm, "_lval_fall"}, lf[i], 1);
        if (w > 0) for (int i = i_dc; i < dc.size(); i++) check({nm, "_dval_per_line"}, dc[i], w);
        for (int i = i_hg; i < hg.size(); i++)
            if (exact) check({nm, "_hgap"}, hg[i], HB);
            else check({nm, "_hgap_min"}, int'(hg[i] >= HB), 1);
        for (int i = i_fg; i < fg.size(); i++)
            if (exact) check({nm, "_vgap"}, fg[i], VB + 1);
            else check({nm, "_vgap_min"}, int'(fg[i] >= VB + 1), 1);
        if (exact) for (int i = i_ff; i < ff.size(); i++) check({nm, "_fval_fall"}, ff[i], 1);
    endtask

    initial begin
        int c0;
        s_vb_val = 1'b1;
        s_vb_aux = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fval", fval, 0);
        check("rst_lval", lval, 0);
        check("rst_dval", dval, 0);
        check("rst_pix", pix_data, 0);
        check("rst_err", frm_err, 0);
        check("rst_rdy", s_vb_rdy, 0);
        rst = 1'b0;
        s_vb_val = 1'b0;
        idle(3);

        // always-valid frames with exact blanking and latency
        mark();
        rand_val = 0;
        gen_frame(LINES, 4, 0, 13'h1ABC);
        gen_frame(LINES, 4, 0, 13'($urandom));
        c0 = cyc;
        endph("p1", 2, 4, 1);
        check("p1_fval_rise", fr[i_fr], c0 + 1);
        check("p1_first_dval", fd[i_fd], c0 + GAP + 2);
        check("p1_msb_pix", fp[i_fd], 13'h1ABC);

        // val toggling inside lines
        mark();
        rand_val = 1;
        gen_frame(LINES, 4, 0, 13'($urandom));
        gen_frame(LINES, 4, 0, 13'($urandom));
        endph("p2", 2, 4, 0);

        // non-SOF beats while idle are dropped
        mark();
        for (int i = 0; i < 3; i++) push({2'b00, 1'($urandom_range(0, 1)), 1'b0}, 12'($urandom));
        gen_frame(LINES, 4, 0, 13'($urandom));
        endph("p3", 1, 4, 0);

        // short frame: SOF after two lines restarts the frame
        mark();
        rand_val = 0;
        gen_frame(2, 4, 0, 13'($urandom));
        gen_frame(LINES, 4, 0, 13'h05A5);
        endph("p4", 2, 4, 0);
        check("p4_restart_pix", fp[i_fd + 1], 13'h05A5);

        // random widths, random val, stray mid-line SOF beats
        mark();
        rand_val = 1;
        for (int f = 0; f < 3; f++) gen_frame(LINES, $urandom_range(1, 6), 1, 13'($urandom));
        endph("p5", 3, 0, 0);

        // reset in the middle of a line
        mark();
        rand_val = 0;
        gen_frame(LINES, 8, 0, 13'($urandom));
        run(GAP + 8, 0);
        check("pre_rst_lval", lval, 1);
        rst = 1'b1;
        s_vb_val = 1'b1;
        s_vb_aux = 4'b0000;
        #1;
        check("mid_rst_fval", fval, 0);
        check("mid_rst_lval", lval, 0);
        check("mid_rst_dval", dval, 0);
        check("mid_rst_pix", pix_data, 0);
        check("mid_rst_rdy", s_vb_rdy, 0);
        idle(3);
        check("mid_rst_hold_fval", fval, 0);
        rst = 1'b0;
        s_vb_val = 1'b0;
        bq.delete();
        expq.delete();
        m_open = 0;
        idle(VB + 5);
        mark();
        gen_frame(LINES, 4, 0, 13'($urandom));
        endph("p6", 1, 4, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
